grf_wr_arbiter: RTL and testbench

- Shares the single GRF write port (WE/A3/WD/PC) between two requesters.
- Requester A is the pipeline W-stage writeback. Requester B is the multi-cycle unit writeback (mult/div result move, delayed loads).
- Registered output stage drives the GRF directly; its contents also serve the hazard unit as the in-flight write.
- Fixed priority to A, with a starvation guard that forces a B grant.

---
 rtl/grf_wr_arbiter_if.sv | 31 +++
 rtl/grf_wr_arbiter.sv | 104 ++++++++++
 tb/tb_grf_wr_arbiter.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/grf_wr_arbiter_if.sv
// GRF write-port bundle: two requester handshakes, the registered GRF write and the boost flag.
// master = requester/observer side, slave = arbiter side.
interface grf_wr_arbiter_if;
  logic        a_valid;
  logic        a_ready;
  logic [4:0]  a_addr;
  logic [31:0] a_data;
  logic [31:0] a_pc;
  logic        b_valid;
  logic        b_ready;
  logic [4:0]  b_addr;
  logic [31:0] b_data;
  logic [31:0] b_pc;
  logic        grf_we;
  logic [4:0]  grf_a3;
  logic [31:0] grf_wd;
  logic [31:0] grf_pc;
  logic        b_boost;

  modport master (
    output a_valid, a_addr, a_data, a_pc,
    output b_valid, b_addr, b_data, b_pc,
    input  a_ready, b_ready, grf_we, grf_a3, grf_wd, grf_pc, b_boost
  );

  modport slave (
    input  a_valid, a_addr, a_data, a_pc,
    input  b_valid, b_addr, b_data, b_pc,
    output a_ready, b_ready, grf_we, grf_a3, grf_wd, grf_pc, b_boost
  );
endinterface

// File: rtl/grf_wr_arbiter.sv
// Two-requester arbiter for the single GRF write port: fixed priority to A with a B starvation guard,
// or a 1-bit round-robin pointer when GRF_ARB_RR_EN is defined.
module grf_wr_arbiter #(
  parameter int unsigned STARVE_LIMIT = 3
) (
  input logic             clk,
  input logic             reset,
  grf_wr_arbiter_if.slave bus
);

  logic        a_rdy;
  logic        b_rdy;
  logic        a_gnt;
  logic        b_gnt;

  logic        grf_we_q, grf_we_d;
  logic [4:0]  grf_a3_q, grf_a3_d;
  logic [31:0] grf_wd_q, grf_wd_d;
  logic [31:0] grf_pc_q, grf_pc_d;

`ifdef GRF_ARB_RR_EN
  // Pointer 0 favours A, 1 favours B; it only moves when both sides compete.
  logic rr_q, rr_d;

  always_comb begin
    a_rdy = reset & (!bus.b_valid | !rr_q);
    b_rdy = reset & (!bus.a_valid | rr_q);
    rr_d  = rr_q;
    if (bus.a_valid && bus.b_valid) rr_d = !rr_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rr_q <= 1'b0;
    else        rr_q <= rr_d;
  end

  assign bus.b_boost = 1'b0;
`else
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt_q, starve_cnt_d;
  logic       boost;

  always_comb begin
    boost        = reset & bus.b_valid & (starve_cnt_q == LIMIT);
    a_rdy        = reset & !boost;
    b_rdy        = reset & (boost | !bus.a_valid);
    starve_cnt_d = 4'd0;
    if (bus.b_valid && !b_rdy)
      starve_cnt_d = (starve_cnt_q == LIMIT) ? starve_cnt_q : starve_cnt_q + 4'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) starve_cnt_q <= 4'd0;
    else        starve_cnt_q <= starve_cnt_d;
  end

  assign bus.b_boost = boost;
`endif

  assign a_gnt = bus.a_valid & a_rdy;
  assign b_gnt = bus.b_valid & b_rdy;

  // Granted fields load the output stage; $0 is accepted but never raises the write enable.
  always_comb begin
    grf_we_d = 1'b0;
    grf_a3_d = grf_a3_q;
    grf_wd_d = grf_wd_q;
    grf_pc_d = grf_pc_q;
    if (a_gnt) begin
      grf_we_d = (bus.a_addr != 5'd0);
      grf_a3_d = bus.a_addr;
      grf_wd_d = bus.a_data;
      grf_pc_d = bus.a_pc;
    end else if (b_gnt) begin
      grf_we_d = (bus.b_addr != 5'd0);
      grf_a3_d = bus.b_addr;
      grf_wd_d = bus.b_data;
      grf_pc_d = bus.b_pc;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grf_we_q <= 1'b0;
      grf_a3_q <= 5'd0;
      grf_wd_q <= 32'd0;
      grf_pc_q <= 32'd0;
    end else begin
      grf_we_q <= grf_we_d;
      grf_a3_q <= grf_a3_d;
      grf_wd_q <= grf_wd_d;
      grf_pc_q <= grf_pc_d;
    end
  end

  assign bus.a_ready = a_rdy;
  assign bus.b_ready = b_rdy;
  assign bus.grf_we  = grf_we_q;
  assign bus.grf_a3  = grf_a3_q;
  assign bus.grf_wd  = grf_wd_q;
  assign bus.grf_pc  = grf_pc_q;

endmodule

// File: tb/tb_grf_wr_arbiter.sv
// Directed bench for grf_wr_arbiter: reset behaviour, a vector table of single-requester writes,
// then contention and mid-operation reset sequences.
module tb_grf_wr_arbiter;
  localparam int unsigned STARVE_LIMIT = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  grf_wr_arbiter_if bus ();

  grf_wr_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        a_valid;
    logic [4:0]  a_addr;
    logic [31:0] a_data;
    logic [31:0] a_pc;
    logic        b_valid;
    logic [4:0]  b_addr;
    logic [31:0] b_data;
    logic [31:0] b_pc;
    logic        exp_a_ready;
    logic        exp_b_ready;
    logic        exp_we;
    logic [4:0]  exp_a3;
    logic [31:0] exp_wd;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vec [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic av, input logic [4:0] aa, input logic [31:0] ad, input logic [31:0] ap,
                       input logic bv, input logic [4:0] ba, input logic [31:0] bd, input logic [31:0] bp);
    bus.a_valid = av; bus.a_addr = aa; bus.a_data = ad; bus.a_pc = ap;
    bus.b_valid = bv; bus.b_addr = ba; bus.b_data = bd; bus.b_pc = bp;
  endtask

  initial begin
    //            av  aa     ad            ap            bv  ba     bd            bp            ar    br    we    a3     wd            pc
    vec[0] = '{1'b1, 5'd3,  32'h12345678, 32'h00003000, 1'b0, 5'd0,  32'h0,        32'h0,        1'b1, 1'b0, 1'b1, 5'd3,  32'h12345678, 32'h00003000};
    vec[1] = '{1'b0, 5'd0,  32'h0,        32'h0,        1'b0, 5'd0,  32'h0,        32'h0,        1'b1, 1'b1, 1'b0, 5'd3,  32'h12345678, 32'h00003000};
    vec[2] = '{1'b0, 5'd0,  32'h0,        32'h0,        1'b1, 5'd7,  32'hDEADBEEF, 32'h00004004, 1'b1, 1'b1, 1'b1, 5'd7,  32'hDEADBEEF, 32'h00004004};
    vec[3] = '{1'b1, 5'd0,  32'hFFFFFFFF, 32'h00003008, 1'b0, 5'd0,  32'h0,        32'h0,        1'b1, 1'b0, 1'b0, 5'd0,  32'hFFFFFFFF, 32'h00003008};
    vec[4] = '{1'b0, 5'd0,  32'h0,        32'h0,        1'b1, 5'd0,  32'h00000055, 32'h0000400C, 1'b1, 1'b1, 1'b0, 5'd0,  32'h00000055, 32'h0000400C};
    vec[5] = '{1'b1, 5'd31, 32'hA5A5A5A5, 32'h00003010, 1'b0, 5'd0,  32'h0,        32'h0,        1'b1, 1'b0, 1'b1, 5'd31, 32'hA5A5A5A5, 32'h00003010};
    vec[6] = '{1'b0, 5'd0,  32'h0,        32'h0,        1'b0, 5'd0,  32'h0,        32'h0,        1'b1, 1'b1, 1'b0, 5'd31, 32'hA5A5A5A5, 32'h00003010};
    vec[7] = '{1'b0, 5'd0,  32'h0,        32'h0,        1'b1, 5'd1,  32'h00000001, 32'h00004010, 1'b1, 1'b1, 1'b1, 5'd1,  32'h00000001, 32'h00004010};

    // Reset held with A requesting $5.
    reset = 1'b0;
    drive(1'b1, 5'd5, 32'hCAFE0005, 32'h00000100, 1'b0, 5'd0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_a_ready", 32'(bus.a_ready), 32'd0);
    chk("rst_b_ready", 32'(bus.b_ready), 32'd0);
    chk("rst_we",      32'(bus.grf_we),  32'd0);
    chk("rst_a3",      32'(bus.grf_a3),  32'd0);
    chk("rst_wd",      bus.grf_wd,       32'd0);
    chk("rst_pc",      bus.grf_pc,       32'd0);
    chk("rst_boost",   32'(bus.b_boost), 32'd0);

    reset = 1'b1;
    #1;
    chk("rel_a_ready", 32'(bus.a_ready), 32'd1);
    @(posedge clk); #1;
    chk("rel_we", 32'(bus.grf_we), 32'd1);
    chk("rel_a3", 32'(bus.grf_a3), 32'd5);
    chk("rel_wd", bus.grf_wd,      32'hCAFE0005);
    chk("rel_pc", bus.grf_pc,      32'h00000100);

    // Single-requester vectors.
    for (int i = 0; i < 8; i++) begin
      drive(vec[i].a_valid, vec[i].a_addr, vec[i].a_data, vec[i].a_pc,
            vec[i].b_valid, vec[i].b_addr, vec[i].b_data, vec[i].b_pc);
      #1;
      chk($sformatf("v%0d_a_ready", i), 32'(bus.a_ready), 32'(vec[i].exp_a_ready));
      chk($sformatf("v%0d_b_ready", i), 32'(bus.b_ready), 32'(vec[i].exp_b_ready));
      chk($sformatf("v%0d_boost", i),   32'(bus.b_boost), 32'd0);
      @(posedge clk); #1;
      chk($sformatf("v%0d_we", i), 32'(bus.grf_we), 32'(vec[i].exp_we));
      chk($sformatf("v%0d_a3", i), 32'(bus.grf_a3), 32'(vec[i].exp_a3));
      chk($sformatf("v%0d_wd", i), bus.grf_wd,      vec[i].exp_wd);
      chk($sformatf("v%0d_pc", i), bus.grf_pc,      vec[i].exp_pc);
    end

    // Both requesters valid every cycle.
    drive(1'b1, 5'd10, 32'hAAAA000A, 32'h00003100, 1'b1, 5'd20, 32'hBBBB0014, 32'h00004100);
    for (int k = 0; k < 8; k++) begin
      logic exp_b;
`ifdef GRF_ARB_RR_EN
      exp_b = (k % 2) == 1;
`else
      exp_b = (k % 4) == 3;
`endif
      #1;
      chk($sformatf("c%0d_a_ready", k), 32'(bus.a_ready), 32'(!exp_b));
      chk($sformatf("c%0d_b_ready", k), 32'(bus.b_ready), 32'(exp_b));
`ifdef GRF_ARB_RR_EN
      chk($sformatf("c%0d_boost", k),   32'(bus.b_boost), 32'd0);
`else
      chk($sformatf("c%0d_boost", k),   32'(bus.b_boost), 32'(exp_b));
`endif
      @(posedge clk); #1;
      chk($sformatf("c%0d_we", k), 32'(bus.grf_we), 32'd1);
      chk($sformatf("c%0d_a3", k), 32'(bus.grf_a3), exp_b ? 32'd20 : 32'd10);
      chk($sformatf("c%0d_wd", k), bus.grf_wd,      exp_b ? 32'hBBBB0014 : 32'hAAAA000A);
    end

    // Reset asserted the cycle after a grant drops the in-flight write at once.
    drive(1'b1, 5'd9, 32'h00000099, 32'h00005000, 1'b0, 5'd0, 32'h0, 32'h0);
    @(posedge clk); #1;
    chk("mr_pre_we", 32'(bus.grf_we), 32'd1);
    chk("mr_pre_a3", 32'(bus.grf_a3), 32'd9);
    #1;
    reset = 1'b0;
    #1;
    chk("mr_we",      32'(bus.grf_we),  32'd0);
    chk("mr_a3",      32'(bus.grf_a3),  32'd0);
    chk("mr_a_ready", 32'(bus.a_ready), 32'd0);
    @(posedge clk); #1;
    chk("mr_hold_we", 32'(bus.grf_we), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mr_rel_we", 32'(bus.grf_we), 32'd1);
    chk("mr_rel_a3", 32'(bus.grf_a3), 32'd9);
    chk("mr_rel_wd", bus.grf_wd,      32'h00000099);

    drive(1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h0);
    @(posedge clk); #1;
    chk("end_we", 32'(bus.grf_we), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
